// File: rtl/tag_mux_rr.sv
// Tagged-row word mux: round-robin pick of one requesting row, column select, single-entry output register.
// Latency: 1 cycle, tag/col sampled at edge N -> word on io_out_bits after edge N.
// Backpressure: FULL && !io_out_ready holds the word and freezes arbitration; ready && tags reloads back-to-back.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   io_in         ROWS*COLS words; word [r][c] at bits ((r*COLS+c)*WIDTH) +: WIDTH
//   io_tag        level request per row
//   io_col        column index applied to the winning row (>= COLS selects column 0)
//   io_out_valid  output register holds a word
//   io_out_ready  consumer accepts the held word this cycle
//   io_out_bits   held word
//   io_out_row    row that produced io_out_bits
//   io_grant      one-hot pulse, aligned with the cycle a newly captured word first appears
module tag_mux_rr #(
  parameter  int ROWS  = 8,
  parameter  int COLS  = 8,
  parameter  int WIDTH = 32,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ROWS*COLS*WIDTH-1:0]  io_in,
  input  logic [ROWS-1:0]             io_tag,
  input  logic [CW-1:0]               io_col,
  output logic                        io_out_valid,
  input  logic                        io_out_ready,
  output logic [WIDTH-1:0]            io_out_bits,
  output logic [RW-1:0]               io_out_row,
  output logic [ROWS-1:0]             io_grant
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bits_q,  bits_d;
  logic [RW-1:0]      row_q,   row_d;
  logic [RW-1:0]      ptr_q,   ptr_d;
  logic [ROWS-1:0]    grant_q, grant_d;

  logic [ROWS-1:0]    hi_mask;
  logic [ROWS-1:0]    hi_req;
  logic [RW-1:0]      win_hi;
  logic [RW-1:0]      win_lo;
  logic [RW-1:0]      winner;
  logic [CW-1:0]      col_eff;
  logic [WIDTH-1:0]   sel_word;
  logic               load;

  // Round-robin search: requests at or above ptr take priority; if none,
  // wrap to the lowest requesting row. Both halves pick their lowest set bit.
  always_comb begin
    hi_mask = '0;
    win_hi  = '0;
    win_lo  = '0;
    for (int r = 0; r < ROWS; r++) begin
      hi_mask[r] = (r >= int'(ptr_q));
    end
    hi_req = io_tag & hi_mask;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (hi_req[r]) win_hi = RW'(r);
      if (io_tag[r]) win_lo = RW'(r);
    end
    winner = (|hi_req) ? win_hi : win_lo;
  end

  // Column mux on the winning row; out-of-range columns fall back to column 0.
  always_comb begin
    col_eff  = (int'(io_col) < COLS) ? io_col : '0;
    sel_word = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((RW'(r) == winner) && (CW'(c) == col_eff)) begin
          sel_word = io_in[(r*COLS+c)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Next state: load when any tag is up and the register is empty or draining.
  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    row_d   = row_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    load    = (|io_tag) && ((state_q == EMPTY) || io_out_ready);
    if (load) begin
      state_d = FULL;
      bits_d  = sel_word;
      row_d   = winner;
      // Explicit wrap so non-power-of-2 ROWS never points past the last row.
      ptr_d   = (winner == RW'(ROWS - 1)) ? '0 : winner + RW'(1);
      grant_d = ROWS'(1) << winner;
    end else if ((state_q == FULL) && io_out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      bits_q  <= '0;
      row_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      row_q   <= row_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Valid comes straight from the state register: no combinational path from ready.
  assign io_out_valid = (state_q == FULL);
  assign io_out_bits  = bits_q;
  assign io_out_row   = row_q;
  assign io_grant     = grant_q;

endmodule
